// File: rtl/async_sram_ctrl_pkg.sv
// Shared state encoding, timing defaults and helpers for the async SRAM controller.
// Defining ASYNC_SRAM_CTRL_WRITE_VERIFY_EN adds the VFY_RD state.
package async_sram_ctrl_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_ADDR_W  = 23;
  localparam int DEF_RD_WAIT = 4;
  localparam int DEF_WR_WAIT = 4;
  localparam int DEF_TURN    = 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_STRB = 3'd1,
    WR_STRB = 3'd2,
    WR_HOLD = 3'd3,
    TURN_ST = 3'd4
`ifdef ASYNC_SRAM_CTRL_WRITE_VERIFY_EN
    ,
    VFY_RD  = 3'd5
`endif
  } state_t;

  function automatic int bytes(input int dataW);
    return dataW / 8;
  endfunction

endpackage

// File: rtl/sram_wait_timer.sv
// Loadable down-counter with a zero flag; times strobe widths and bus turnaround.
module sram_wait_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] loadVal,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= loadVal;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/async_sram_ctrl.sv
// Asynchronous-mode SRAM/PSRAM controller with valid/ready requests and byte-lane writes.
// Optional ASYNC_SRAM_CTRL_WRITE_VERIFY_EN re-reads every write and flags lane mismatches.
module async_sram_ctrl
  import async_sram_ctrl_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int RD_WAIT = DEF_RD_WAIT,
  parameter int WR_WAIT = DEF_WR_WAIT,
  parameter int TURN    = DEF_TURN
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   mem_addr,
  inout  wire  [DATA_W-1:0]   mem_dq,
  output logic                mem_ce_n,
  output logic                mem_oe_n,
  output logic                mem_we_n,
  output logic [DATA_W/8-1:0] mem_be_n,
  output logic                mem_adv_n,
  output logic                mem_clk,
  output logic                flash_ce_n
);

  localparam int BE_W     = bytes(DATA_W);
  localparam int MAX_RW   = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int MAX_WAIT = (MAX_RW > TURN) ? MAX_RW : TURN;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);

  localparam logic [CNT_W-1:0] RD_LOAD   = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD   = CNT_W'(WR_WAIT - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'((TURN > 0) ? TURN - 1 : 0);

  if (RD_WAIT < 1) begin : gRdWaitChk
    $error("async_sram_ctrl: RD_WAIT must be >= 1");
  end
  if (WR_WAIT < 1) begin : gWrWaitChk
    $error("async_sram_ctrl: WR_WAIT must be >= 1");
  end
  if ((DATA_W % 8) != 0) begin : gDataWChk
    $error("async_sram_ctrl: DATA_W must be a multiple of 8");
  end

  state_t            state;
  logic              accept;
  logic              dqOe;
  logic [DATA_W-1:0] wdataReg;
  logic              tmrLoad;
  logic [CNT_W-1:0]  tmrVal;
  logic              tmrZero;

  assign req_ready  = (state == IDLE);
  assign accept     = req_valid && req_ready;
  assign mem_dq     = dqOe ? wdataReg : {DATA_W{1'bz}};
  assign mem_adv_n  = 1'b0;
  assign mem_clk    = 1'b0;
  assign flash_ce_n = 1'b1;

`ifdef ASYNC_SRAM_CTRL_WRITE_VERIFY_EN
  logic [BE_W-1:0]   beReg;
  logic [DATA_W-1:0] laneMask;
  logic              vfyMismatch;
  logic              vfyPending;

  for (genvar b = 0; b < BE_W; b++) begin : gLaneMask
    assign laneMask[b*8 +: 8] = {8{beReg[b]}};
  end
  assign vfyMismatch = |((mem_dq ^ wdataReg) & laneMask);
`else
  assign rsp_err = 1'b0;
`endif

  // Write payload is only consumed while its access is in flight, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      wdataReg <= req_wdata;
`ifdef ASYNC_SRAM_CTRL_WRITE_VERIFY_EN
      beReg    <= req_be;
`endif
    end
  end

  // Timer reload happens on the edge that enters each timed phase.
  always_comb begin
    tmrLoad = 1'b0;
    tmrVal  = TURN_LOAD;
    case (state)
      IDLE: begin
        if (accept) begin
          tmrLoad = 1'b1;
          tmrVal  = req_write ? WR_LOAD : RD_LOAD;
        end
      end
      RD_STRB: tmrLoad = tmrZero;
      WR_HOLD: begin
        tmrLoad = 1'b1;
`ifdef ASYNC_SRAM_CTRL_WRITE_VERIFY_EN
        if (TURN == 0) tmrVal = RD_LOAD;
`endif
      end
`ifdef ASYNC_SRAM_CTRL_WRITE_VERIFY_EN
      TURN_ST: begin
        if (tmrZero && vfyPending) begin
          tmrLoad = 1'b1;
          tmrVal  = RD_LOAD;
        end
      end
      VFY_RD: tmrLoad = tmrZero;
`endif
      default: tmrLoad = 1'b0;
    endcase
  end

  sram_wait_timer #(
    .CNT_W(CNT_W)
  ) uTimer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmrLoad),
    .loadVal(tmrVal),
    .zero   (tmrZero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_ce_n  <= 1'b1;
      mem_oe_n  <= 1'b1;
      mem_we_n  <= 1'b1;
      mem_be_n  <= '1;
      dqOe      <= 1'b0;
      mem_addr  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
`ifdef ASYNC_SRAM_CTRL_WRITE_VERIFY_EN
      rsp_err    <= 1'b0;
      vfyPending <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            mem_addr <= req_addr;
            mem_ce_n <= 1'b0;
            if (req_write) begin
              state    <= WR_STRB;
              mem_we_n <= 1'b0;
              mem_be_n <= ~req_be;
              dqOe     <= 1'b1;
            end else begin
              state    <= RD_STRB;
              mem_oe_n <= 1'b0;
              mem_be_n <= '0;
            end
          end
        end
        RD_STRB: begin
          if (tmrZero) begin
            rsp_rdata <= mem_dq;
            rsp_valid <= 1'b1;
`ifdef ASYNC_SRAM_CTRL_WRITE_VERIFY_EN
            rsp_err   <= 1'b0;
`endif
            mem_ce_n  <= 1'b1;
            mem_oe_n  <= 1'b1;
            mem_be_n  <= '1;
            if (TURN > 0) state <= TURN_ST;
            else          state <= IDLE;
          end
        end
        WR_STRB: begin
          if (tmrZero) begin
            mem_ce_n <= 1'b1;
            mem_we_n <= 1'b1;
            mem_be_n <= '1;
            state    <= WR_HOLD;
          end
        end
        WR_HOLD: begin
          dqOe <= 1'b0;
`ifdef ASYNC_SRAM_CTRL_WRITE_VERIFY_EN
          if (TURN > 0) begin
            state      <= TURN_ST;
            vfyPending <= 1'b1;
          end else begin
            state    <= VFY_RD;
            mem_ce_n <= 1'b0;
            mem_oe_n <= 1'b0;
            mem_be_n <= '0;
          end
`else
          rsp_valid <= 1'b1;
          if (TURN > 0) state <= TURN_ST;
          else          state <= IDLE;
`endif
        end
        TURN_ST: begin
          if (tmrZero) begin
`ifdef ASYNC_SRAM_CTRL_WRITE_VERIFY_EN
            if (vfyPending) begin
              vfyPending <= 1'b0;
              state      <= VFY_RD;
              mem_ce_n   <= 1'b0;
              mem_oe_n   <= 1'b0;
              mem_be_n   <= '0;
            end else begin
              state <= IDLE;
            end
`else
            state <= IDLE;
`endif
          end
        end
`ifdef ASYNC_SRAM_CTRL_WRITE_VERIFY_EN
        // Verify read leaves rsp_rdata untouched; only the error flag reports it.
        VFY_RD: begin
          if (tmrZero) begin
            rsp_valid <= 1'b1;
            rsp_err   <= vfyMismatch;
            mem_ce_n  <= 1'b1;
            mem_oe_n  <= 1'b1;
            mem_be_n  <= '1;
            if (TURN > 0) state <= TURN_ST;
            else          state <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_async_sram_ctrl.sv
// Directed scoreboard bench: u0 runs with TURN=1, u1 with TURN=0 for back-to-back reads.
module tb_async_sram_ctrl;

  localparam int RD_WAIT = 4;
  localparam int WR_WAIT = 4;
  localparam int RLAT    = RD_WAIT + 1;
`ifdef ASYNC_SRAM_CTRL_WRITE_VERIFY_EN
  localparam int   WLAT    = WR_WAIT + 2 + 1 + RD_WAIT;
  localparam logic VFY_ERR = 1'b1;
`else
  localparam int   WLAT    = WR_WAIT + 2;
  localparam logic VFY_ERR = 1'b0;
`endif

  typedef struct packed {
    logic        wr;
    logic [15:0] rd;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nAsrt = 0;
  int   nFail = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        valid0 = 0, write0 = 0, rdy0, rspV0, err0, ceN0, oeN0, weN0, advN0, mclk0, fceN0;
  logic [22:0] addr0 = '0, maddr0;
  logic [15:0] wdata0 = '0, rdata0;
  logic [1:0]  be0 = '0, beN0;
  wire  [15:0] dq0;
  logic        valid1 = 0, write1 = 0, rdy1, rspV1, err1, ceN1, oeN1, weN1, advN1, mclk1, fceN1;
  logic [22:0] addr1 = '0, maddr1;
  logic [15:0] wdata1 = '0, rdata1;
  logic [1:0]  be1 = '0, beN1;
  wire  [15:0] dq1;

  async_sram_ctrl #(.DATA_W(16), .ADDR_W(23), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT), .TURN(1)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid0), .req_ready(rdy0), .req_write(write0),
    .req_addr(addr0), .req_wdata(wdata0), .req_be(be0), .rsp_valid(rspV0), .rsp_rdata(rdata0),
    .rsp_err(err0), .mem_addr(maddr0), .mem_dq(dq0), .mem_ce_n(ceN0), .mem_oe_n(oeN0),
    .mem_we_n(weN0), .mem_be_n(beN0), .mem_adv_n(advN0), .mem_clk(mclk0), .flash_ce_n(fceN0));

  async_sram_ctrl #(.DATA_W(16), .ADDR_W(23), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT), .TURN(0)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid1), .req_ready(rdy1), .req_write(write1),
    .req_addr(addr1), .req_wdata(wdata1), .req_be(be1), .rsp_valid(rspV1), .rsp_rdata(rdata1),
    .rsp_err(err1), .mem_addr(maddr1), .mem_dq(dq1), .mem_ce_n(ceN1), .mem_oe_n(oeN1),
    .mem_we_n(weN1), .mem_be_n(beN1), .mem_adv_n(advN1), .mem_clk(mclk1), .flash_ce_n(fceN1));

  // Async SRAM models; word 0x30 of mem0 has data bit 3 stuck at 0.
  logic [15:0] mem0 [0:255];
  logic [15:0] mem1 [0:255];
  assign dq0 = (!ceN0 && !oeN0) ? mem0[maddr0[7:0]] : 16'hzzzz;
  assign dq1 = (!ceN1 && !oeN1) ? mem1[maddr1[7:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (!ceN0 && !weN0) begin
      for (int b = 0; b < 2; b++)
        if (!beN0[b]) mem0[maddr0[7:0]][b*8 +: 8] <= dq0[b*8 +: 8];
      if (maddr0[7:0] == 8'h30) mem0[8'h30][3] <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsrt++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t e0, e1;
  logic [15:0] lastRd0 = '0, lastRd1 = '0;

  // Scoreboard pops and per-cycle bus rules
  always @(negedge clk) begin
    if (!rst_n) begin
      lastRd0 = '0;
      lastRd1 = '0;
    end else begin
      if (rspV0) begin
        if (sb0.size() == 0) chk("rsp0_unexpected", 32'(rspV0), 32'(0));
        else begin
          e0 = sb0.pop_front();
          chk("rsp0_err", 32'(err0), 32'(e0.err));
          if (e0.wr) chk("rsp0_rdata_hold", 32'(rdata0), 32'(lastRd0));
          else begin
            chk("rsp0_rdata", 32'(rdata0), 32'(e0.rd));
            lastRd0 = e0.rd;
          end
        end
      end
      if (rspV1) begin
        if (sb1.size() == 0) chk("rsp1_unexpected", 32'(rspV1), 32'(0));
        else begin
          e1 = sb1.pop_front();
          chk("rsp1_err", 32'(err1), 32'(e1.err));
          chk("rsp1_rdata", 32'(rdata1), 32'(e1.rd));
          lastRd1 = e1.rd;
        end
      end
      chk("oe_we_overlap0", 32'(!oeN0 && !weN0), 32'(0));
      chk("oe_we_overlap1", 32'(!oeN1 && !weN1), 32'(0));
      chk("ready_in_strobe0", 32'(rdy0 && !ceN0), 32'(0));
      chk("ready_in_strobe1", 32'(rdy1 && !ceN1), 32'(0));
      chk("tied_pins0", 32'({advN0, mclk0, fceN0}), 32'(3'b001));
      chk("tied_pins1", 32'({advN1, mclk1, fceN1}), 32'(3'b001));
    end
  end

  task automatic waitReady0();
    int n = 0;
    while (!rdy0 && n < 100) begin @(negedge clk); n++; end
    chk("ready0_timeout", 32'(rdy0), 32'(1));
  endtask

  // Issue one request on u0 and time its completion from the accept edge.
  task automatic issue0(input logic wr, input logic [22:0] a, input logic [15:0] d,
                        input logic [1:0] be, input logic [15:0] expRd, input logic expErr,
                        input int expLat, input logic [1:0] expBeN);
    int lat;
    int weLow;
    logic [1:0] beSeen;
    waitReady0();
    valid0 = 1'b1; write0 = wr; addr0 = a; wdata0 = d; be0 = be;
    sb0.push_back(exp_t'{wr, expRd, expErr});
    @(negedge clk);
    valid0 = 1'b0;
    lat = 1; weLow = 0; beSeen = 2'b11;
    while (!rspV0 && lat < 100) begin
      if (!weN0) begin weLow++; beSeen = beN0; end
      chk("addr_stable", 32'(maddr0), 32'(a));
      @(negedge clk);
      lat++;
    end
    chk(wr ? "write_latency" : "read_latency", 32'(lat), 32'(expLat));
    chk("we_low_cycles", 32'(weLow), wr ? 32'(WR_WAIT) : 32'(0));
    if (wr) chk("write_be_n", 32'(beSeen), 32'(expBeN));
  endtask

  initial begin
    int n;
    int accCyc [3];
    for (int i = 0; i < 256; i++) mem1[i] = 16'h1000 + 16'(i);

    repeat (3) @(negedge clk);
    chk("rst_strobes0", 32'({ceN0, oeN0, weN0, beN0}), 32'(5'b11111));
    chk("rst_addr0", 32'(maddr0), 32'(0));
    chk("rst_rsp0", 32'({rspV0, err0, rdata0}), 32'(0));
    chk("rst_strobes1", 32'({ceN1, oeN1, weN1, beN1}), 32'(5'b11111));
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("ready0_after_rst", 32'(rdy0), 32'(1));
    chk("ready1_after_rst", 32'(rdy1), 32'(1));

    issue0(1'b1, 23'h10, 16'hBEEF, 2'b11, 16'h0, 1'b0, WLAT, 2'b00);
    issue0(1'b0, 23'h10, 16'h0000, 2'b11, 16'hBEEF, 1'b0, RLAT, 2'b11);
    issue0(1'b1, 23'h20, 16'h1234, 2'b11, 16'h0, 1'b0, WLAT, 2'b00);
    issue0(1'b1, 23'h20, 16'hAB00, 2'b10, 16'h0, 1'b0, WLAT, 2'b01);
    issue0(1'b1, 23'h41, 16'hFFFF, 2'b11, 16'h0, 1'b0, WLAT, 2'b00);
    issue0(1'b0, 23'h20, 16'h0000, 2'b11, 16'hAB34, 1'b0, RLAT, 2'b11);
    issue0(1'b1, 23'h20, 16'h5555, 2'b00, 16'h0, 1'b0, WLAT, 2'b11);
    issue0(1'b0, 23'h20, 16'h0000, 2'b11, 16'hAB34, 1'b0, RLAT, 2'b11);
    issue0(1'b1, 23'h30, 16'h0008, 2'b11, 16'h0, VFY_ERR, WLAT, 2'b00);
    issue0(1'b1, 23'h30, 16'h0001, 2'b11, 16'h0, 1'b0, WLAT, 2'b00);

    // Back-to-back reads on u1 with req_valid held high
    valid1 = 1'b1; write1 = 1'b0; be1 = 2'b11;
    for (int k = 0; k < 3; k++) begin
      addr1 = 23'(16 + k);
      sb1.push_back(exp_t'{1'b0, 16'h1010 + 16'(k), 1'b0});
      n = 0;
      while (!rdy1 && n < 100) begin @(negedge clk); n++; end
      chk("ready1_timeout", 32'(rdy1), 32'(1));
      accCyc[k] = cyc;
      @(negedge clk);
    end
    valid1 = 1'b0;
    chk("b2b_gap01", 32'(accCyc[1] - accCyc[0]), 32'(RD_WAIT + 1));
    chk("b2b_gap12", 32'(accCyc[2] - accCyc[1]), 32'(RD_WAIT + 1));
    n = 0;
    while (sb1.size() != 0 && n < 50) begin @(negedge clk); n++; end
    chk("b2b_drain", 32'(sb1.size()), 32'(0));

    // Reset during the second WR_STRB cycle of a write on u0
    waitReady0();
    valid0 = 1'b1; write0 = 1'b1; addr0 = 23'h50; wdata0 = 16'h7777; be0 = 2'b11;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("midwrite_we_low", 32'(weN0), 32'(0));
    rst_n = 1'b0;
    valid0 = 1'b0;
    #1;
    chk("midwrite_rst_strobes", 32'({ceN0, oeN0, weN0, beN0}), 32'(5'b11111));
    chk("midwrite_rst_rsp", 32'(rspV0), 32'(0));
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("ready0_after_midrst", 32'(rdy0), 32'(1));
    chk("rdata0_after_midrst", 32'(rdata0), 32'(0));
    repeat (8) @(negedge clk);
    chk("no_rsp_after_midrst", 32'(rspV0), 32'(0));
    issue0(1'b0, 23'h10, 16'h0000, 2'b11, 16'hBEEF, 1'b0, RLAT, 2'b11);
    repeat (4) @(negedge clk);
    chk("sb0_drained", 32'(sb0.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", nAsrt, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/async_sram_ctrl.md
Name: async_sram_ctrl

Overview:
- Parametrised asynchronous-mode controller for the board's external SRAM/PSRAM; successor to the fixed 16-bit, fixed-wait single-request controller.
- Adds:
  - configurable data/address width;
  - independent read/write wait counts;
  - byte-lane writes;
  - valid/ready request handshake with a one-cycle response pulse;
  - bus-turnaround recovery.
- Sits between the network weight/activation fetch logic and the memory pins.

Parameters:
- DATA_W, 16: memory data width in bits; multiple of 8.
- ADDR_W, 23: word address width.
- RD_WAIT, 4: cycles CE#/OE# are held low per read; must be >= 1 (elaboration error otherwise).
- WR_WAIT, 4: cycles CE#/WE# are held low per write; must be >= 1.
- TURN, 1: idle cycles after every access before the next request is accepted; 0 is allowed.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- req_valid, in, 1: request present.
- req_ready, out, 1: controller can accept a request this cycle.
- req_write, in, 1: 1 = write, 0 = read.
- req_addr, in, ADDR_W: word address.
- req_wdata, in, DATA_W: write data.
- req_be, in, DATA_W/8: write byte enables, active-high.
- rsp_valid, out, 1: one-cycle completion pulse.
- rsp_rdata, out, DATA_W: read data; held until the next read completes.
- rsp_err, out, 1: write-verify mismatch, qualified by rsp_valid.
- mem_addr, out, ADDR_W: memory address.
- mem_dq, inout, DATA_W: memory data bus.
- mem_ce_n, out, 1: chip enable, active-low.
- mem_oe_n, out, 1: output enable, active-low.
- mem_we_n, out, 1: write enable, active-low.
- mem_be_n, out, DATA_W/8: byte-lane enables (LB#/UB# generalised), active-low.
- mem_adv_n, out, 1: tied 0.
- mem_clk, out, 1: tied 0.
- flash_ce_n, out, 1: tied 1.

Behaviour:
- Reset (async assert, sync release):
  - mem_ce_n = mem_oe_n = mem_we_n = 1, mem_be_n all 1, mem_dq tristate;
  - mem_addr = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, state IDLE;
  - req_ready = 1 after the first clock.
- Reset mid-access: strobes deassert immediately; the in-flight request is dropped and no rsp_valid is produced.
- Handshake:
  - Accept on the edge where req_valid && req_ready; req_addr, req_wdata, req_be and req_write are registered at that edge.
  - req_ready = 1 only in IDLE and is combinational from state only.
  - The master must hold its request while req_ready = 0.
- States:
  - IDLE -> RD_STRB or WR_STRB on accept.
  - RD_STRB -> TURN_ST or IDLE.
  - WR_STRB -> WR_HOLD -> TURN_ST or IDLE.
  - TURN_ST -> IDLE after TURN cycles.
- RD_STRB:
  - mem_ce_n = 0, mem_oe_n = 0, mem_be_n = 0, mem_dq tristate, down-counter loaded with RD_WAIT-1.
  - On the edge where the counter reaches 0: capture mem_dq into rsp_rdata, pulse rsp_valid, deassert strobes.
  - Read latency: rsp_valid is high in the cycle after accept edge + RD_WAIT edges.
- WR_STRB:
  - mem_dq driven with registered data, mem_ce_n = 0, mem_we_n = 0, mem_be_n = ~req_be, held WR_WAIT cycles.
- WR_HOLD (1 cycle):
  - mem_we_n = 1, mem_ce_n = 1, mem_dq still driven (data hold); rsp_valid pulses at the exit edge.
- Write with req_be = 0: timing unchanged, no lane written.
- mem_dq is never driven while mem_oe_n = 0.
- TURN_ST: all strobes high, mem_dq tristate.
- TURN = 0: completion goes straight to IDLE, so back-to-back requests are accepted on the next edge.
- mem_addr changes only at the accept edge; it is stable for the whole access.
- rsp_err = 0 whenever verify is compiled out.

Optional Feature:
- Macro: ASYNC_SRAM_CTRL_WRITE_VERIFY_EN.
- Defined:
  - After WR_HOLD, the controller performs an internal RD_STRB to the same address (plus TURN recovery before it).
  - It compares the enabled lanes of the read data against the write data.
  - rsp_valid for the write is issued at the end of that read, with rsp_err = 1 on any mismatch.
  - rsp_rdata is not updated by the verify read.
- Undefined: write completes at WR_HOLD exit; rsp_err is tied 0.

Decomposition:
- Package async_sram_ctrl_pkg holds:
  - the state enum (IDLE, RD_STRB, WR_STRB, WR_HOLD, TURN_ST, plus VFY_RD when the macro is defined);
  - default timing constants;
  - the function bytes(DATA_W).
- One sub-module, sram_wait_timer: loadable down-counter with a zero flag, shared by the strobe and turnaround phases.

Test Plan:
- Write then read, RD_WAIT = WR_WAIT = 4, TURN = 1: write 0xBEEF @ 0x000010, then read 0x000010 -> mem_we_n low exactly 4 cycles; rsp_rdata = 0xBEEF; rsp_valid high in the 5th cycle after the read accept.
- Byte lanes: write 0x1234 then 0xAB00 with be = 2'b10 @ 0x20; read -> 0xAB34; mem_be_n = 2'b01 during the second write.
- Back-to-back, TURN = 0: req_valid held for 3 reads -> accept spacing is RD_WAIT+1 cycles; req_ready is never high while the strobes are low.
- Bus contention: for all traffic, assert that mem_dq is not driven while mem_oe_n = 0 and that mem_adv_n = mem_clk = 0, flash_ce_n = 1.
- Reset mid-write: assert rst_n low on the 2nd WR_STRB cycle -> strobes high and mem_dq tristate in the same cycle; no rsp_valid after release; the next request behaves normally.
- With ASYNC_SRAM_CTRL_WRITE_VERIFY_EN: memory model forces bit 3 stuck-at-0; write 0x0008 -> rsp_err = 1 with rsp_valid. Write 0x0001 -> rsp_err = 0.
